lbus_sclk_clk_bridge: RTL and testbench

//  Clock-domain bridge between the SPI slave's local-bus outputs (sclk domain) and the register map (clk domain).

---
 rtl/lbus_sclk_clk_bridge_pkg.sv | 17 +
 rtl/lbus_sclk_clk_bridge_if.sv | 33 +++
 rtl/lbus_bit_sync.sv | 20 ++
 rtl/lbus_sclk_clk_bridge.sv | 148 ++++++++++++++
 tb/tb_lbus_sclk_clk_bridge.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lbus_sclk_clk_bridge_pkg.sv
// Shared types and widths for the SPI local-bus to register-map clock bridge.
package lbus_pkg;

  localparam int unsigned LBUS_ADDR_W = 16;
  localparam int unsigned LBUS_DATA_W = 8;
  localparam int unsigned LBUS_CNT_W  = 16;

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    CAPTURE,
    STROBE,
    RDCAP,
    WAIT_LOW
  } lbus_state_e;

endpackage

// File: rtl/lbus_sclk_clk_bridge_if.sv
// Local-bus bundle: sclk-side request/data, regmap strobes and debug status.
interface lbus_sclk_clk_bridge_if
  import lbus_pkg::*;
#(
  parameter int unsigned ADDR_W = LBUS_ADDR_W,
  parameter int unsigned DATA_W = LBUS_DATA_W
);

  logic                  rd_en_sclk;
  logic                  wr_en_sclk;
  logic [ADDR_W-1:0]     address_sclk;
  logic [DATA_W-1:0]     wdata_sclk;
  logic [DATA_W-1:0]     rdata_reg;
  logic                  clr_status;
  logic                  rd_strobe;
  logic                  wr_strobe;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  overrun;
  logic [LBUS_CNT_W-1:0] xfer_count;

  modport master (
    input  rd_en_sclk, wr_en_sclk, address_sclk, wdata_sclk, rdata_reg, clr_status,
    output rd_strobe, wr_strobe, address, wdata, rdata, overrun, xfer_count
  );

  modport slave (
    output rd_en_sclk, wr_en_sclk, address_sclk, wdata_sclk, rdata_reg, clr_status,
    input  rd_strobe, wr_strobe, address, wdata, rdata, overrun, xfer_count
  );

endinterface

// File: rtl/lbus_bit_sync.sv
// Single-bit multi-flop synchroniser into the clk domain.
module lbus_bit_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/lbus_sclk_clk_bridge.sv
// Moves SPI-slave local-bus requests from sclk into clk as single rd/wr strobes,
// captures address/wdata, holds read data, and keeps overrun/transfer debug status.
module lbus_sclk_clk_bridge
  import lbus_pkg::*;
#(
  parameter int unsigned ADDR_W      = LBUS_ADDR_W,
  parameter int unsigned DATA_W      = LBUS_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  lbus_sclk_clk_bridge_if.master bus
);

  localparam int unsigned WARM_W = 3;

  lbus_state_e           state_q, state_nxt;
  logic                  rd_s, wr_s;
  logic                  rd_prev_q, wr_prev_q, rd_rise_q, wr_rise_q;
  logic                  other_rise_c;
  logic                  is_wr_q, is_wr_nxt;
  logic [WARM_W-1:0]     warm_q, warm_nxt;
  logic                  rd_strobe_q, rd_strobe_nxt, wr_strobe_q, wr_strobe_nxt;
  logic [ADDR_W-1:0]     address_q, address_nxt;
  logic [DATA_W-1:0]     wdata_q, wdata_nxt, rdata_q, rdata_nxt;
  logic                  overrun_q, overrun_nxt;
  logic [LBUS_CNT_W-1:0] xfer_q, xfer_nxt;

  lbus_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(clk), .rst_n(rst_n), .d(bus.rd_en_sclk), .q(rd_s)
  );

  lbus_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(clk), .rst_n(rst_n), .d(bus.wr_en_sclk), .q(wr_s)
  );

  // Registered 0->1 detect on the synchronised levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
      rd_rise_q <= 1'b0;
      wr_rise_q <= 1'b0;
    end else begin
      rd_prev_q <= rd_s;
      wr_prev_q <= wr_s;
      rd_rise_q <= rd_s & ~rd_prev_q;
      wr_rise_q <= wr_s & ~wr_prev_q;
    end
  end

  assign other_rise_c = is_wr_q ? rd_rise_q : wr_rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARM;
      is_wr_q     <= 1'b0;
      warm_q      <= '0;
      rd_strobe_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      address_q   <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      overrun_q   <= 1'b0;
      xfer_q      <= '0;
    end else begin
      state_q     <= state_nxt;
      is_wr_q     <= is_wr_nxt;
      warm_q      <= warm_nxt;
      rd_strobe_q <= rd_strobe_nxt;
      wr_strobe_q <= wr_strobe_nxt;
      address_q   <= address_nxt;
      wdata_q     <= wdata_nxt;
      rdata_q     <= rdata_nxt;
      overrun_q   <= overrun_nxt;
      xfer_q      <= xfer_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    is_wr_nxt     = is_wr_q;
    warm_nxt      = warm_q;
    rd_strobe_nxt = 1'b0;
    wr_strobe_nxt = 1'b0;
    address_nxt   = address_q;
    wdata_nxt     = wdata_q;
    rdata_nxt     = rdata_q;
    overrun_nxt   = overrun_q;
    xfer_nxt      = xfer_q;

    if ((state_q inside {CAPTURE, STROBE, RDCAP, WAIT_LOW}) && other_rise_c)
      overrun_nxt = 1'b1;

    case (state_q)
      // Let the synchronisers fill before trusting the levels, so an enable
      // already high at reset release never looks like a fresh request.
      ARM: begin
        if (warm_q < WARM_W'(SYNC_STAGES)) warm_nxt = warm_q + WARM_W'(1);
        else if (!rd_s && !wr_s)           state_nxt = IDLE;
      end
      IDLE: begin
        if (wr_rise_q) begin
          state_nxt = CAPTURE;
          is_wr_nxt = 1'b1;
          if (rd_rise_q) overrun_nxt = 1'b1;
        end else if (rd_rise_q) begin
          state_nxt = CAPTURE;
          is_wr_nxt = 1'b0;
        end
      end
      CAPTURE: begin
        address_nxt = bus.address_sclk;
        if (is_wr_q) begin
          wdata_nxt     = bus.wdata_sclk;
          wr_strobe_nxt = 1'b1;
        end else begin
          rd_strobe_nxt = 1'b1;
        end
        xfer_nxt  = xfer_q + LBUS_CNT_W'(1);
        state_nxt = STROBE;
      end
      STROBE:   state_nxt = is_wr_q ? WAIT_LOW : RDCAP;
      RDCAP: begin
        rdata_nxt = bus.rdata_reg;
        state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!(is_wr_q ? wr_s : rd_s)) state_nxt = IDLE;
      end
      default:  state_nxt = ARM;
    endcase

    if (bus.clr_status) begin
      overrun_nxt = 1'b0;
      xfer_nxt    = '0;
    end
  end

  assign bus.rd_strobe  = rd_strobe_q;
  assign bus.wr_strobe  = wr_strobe_q;
  assign bus.address    = address_q;
  assign bus.wdata      = wdata_q;
  assign bus.rdata      = rdata_q;
  assign bus.overrun    = overrun_q;
  assign bus.xfer_count = xfer_q;

endmodule

// File: tb/tb_lbus_sclk_clk_bridge.sv
// Directed bench for lbus_sclk_clk_bridge: an event-queue model of owed
// strobes/status is compared with the DUT on every falling edge.
`timescale 1ns/1ps
module tb_lbus_sclk_clk_bridge;
  import lbus_pkg::*;

  localparam int N   = 2;
  localparam int LAT = N + 3;  // enable driven at a falling edge -> strobe visible at edge count +LAT

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lbus_sclk_clk_bridge_if bus ();

  lbus_sclk_clk_bridge #(
    .ADDR_W(LBUS_ADDR_W), .DATA_W(LBUS_DATA_W), .SYNC_STAGES(N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  // Register map stand-in: read data appears one clk after rd_strobe, garbage otherwise
  logic [7:0] rd_val = 8'h00;
  always @(posedge clk) bus.rdata_reg <= bus.rd_strobe ? rd_val : 8'hEE;

  typedef enum int {EV_WR, EV_RD, EV_RDATA, EV_OVR, EV_CLR, EV_LOAD} ev_kind_e;
  typedef struct {
    int          at;
    ev_kind_e    kind;
    logic [15:0] a;
    logic [7:0]  d;
  } ev_t;
  ev_t evq[$];

  logic [15:0] m_addr, m_cnt;
  logic [7:0]  m_wdata, m_rdata;
  logic        m_ovr;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endfunction

  always @(negedge clk) begin
    bit exp_rd, exp_wr;
    exp_rd = 1'b0;
    exp_wr = 1'b0;
    if (!rst_n) begin
      evq.delete();
      m_addr = '0; m_cnt = '0; m_wdata = '0; m_rdata = '0; m_ovr = 1'b0;
    end else begin
      foreach (evq[i]) if (evq[i].at == edges) begin
        case (evq[i].kind)
          EV_WR:    begin exp_wr = 1'b1; m_addr = evq[i].a; m_wdata = evq[i].d; m_cnt = m_cnt + 16'd1; end
          EV_RD:    begin exp_rd = 1'b1; m_addr = evq[i].a; m_cnt = m_cnt + 16'd1; end
          EV_RDATA: m_rdata = evq[i].d;
          EV_OVR:   m_ovr = 1'b1;
          EV_LOAD:  m_cnt = evq[i].a;
          default:  ;
        endcase
      end
      // A clear in the same cycle as a strobe or overrun event wins
      foreach (evq[i]) if (evq[i].at == edges && evq[i].kind == EV_CLR) begin
        m_cnt = '0;
        m_ovr = 1'b0;
      end
      for (int i = evq.size() - 1; i >= 0; i--) if (evq[i].at <= edges) evq.delete(i);
    end
    chk("rd_strobe",  bus.rd_strobe,  exp_rd);
    chk("wr_strobe",  bus.wr_strobe,  exp_wr);
    chk("address",    bus.address,    m_addr);
    chk("wdata",      bus.wdata,      m_wdata);
    chk("rdata",      bus.rdata,      m_rdata);
    chk("overrun",    bus.overrun,    m_ovr);
    chk("xfer_count", bus.xfer_count, m_cnt);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic raise(input bit w, input bit r, input logic [15:0] a, input logic [7:0] d, output int e0);
    @(negedge clk);
    bus.address_sclk = a;
    bus.wdata_sclk   = d;
    if (w) bus.wr_en_sclk = 1'b1;
    if (r) bus.rd_en_sclk = 1'b1;
    e0 = edges;
  endtask

  task automatic drop();
    @(negedge clk);
    bus.wr_en_sclk = 1'b0;
    bus.rd_en_sclk = 1'b0;
    idle(N + 4);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    bus.clr_status = 1'b1;
    evq.push_back('{edges + 1, EV_CLR, 16'h0, 8'h0});
    @(negedge clk);
    bus.clr_status = 1'b0;
  endtask

  task automatic write(input logic [15:0] a, input logic [7:0] d, input int hold);
    int e0;
    raise(1'b1, 1'b0, a, d, e0);
    evq.push_back('{e0 + LAT, EV_WR, a, d});
    idle(hold);
    drop();
  endtask

  initial begin
    int e0, e1, seen, n_str;
    bus.rd_en_sclk = 1'b0; bus.wr_en_sclk = 1'b0; bus.clr_status = 1'b0;
    bus.address_sclk = '0; bus.wdata_sclk = '0;

    idle(3);
    chk("reset_strobes", {bus.rd_strobe, bus.wr_strobe}, 2'b00);
    chk("reset_count",   bus.xfer_count, 16'h0000);
    chk("reset_addr",    bus.address, 16'h0000);
    #2 rst_n = 1'b1;
    idle(8);

    // 1: write, measure strobe latency and count
    raise(1'b1, 1'b0, 16'h0012, 8'hA5, e0);
    evq.push_back('{e0 + LAT, EV_WR, 16'h0012, 8'hA5});
    seen = -1; n_str = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.wr_strobe) begin
        n_str++;
        if (seen < 0) seen = edges;
      end
    end
    chk("t1_latency", seen - e0, 5);
    chk("t1_strobes", n_str, 1);
    drop();
    chk("t1_addr",  bus.address, 16'h0012);
    chk("t1_wdata", bus.wdata, 8'hA5);
    chk("t1_count", bus.xfer_count, 16'd1);

    // 2: read, rdata held after the enable drops
    rd_val = 8'h5C;
    raise(1'b0, 1'b1, 16'h0003, 8'h77, e0);
    evq.push_back('{e0 + LAT, EV_RD, 16'h0003, 8'h00});
    evq.push_back('{e0 + LAT + 2, EV_RDATA, 16'h0, 8'h5C});
    idle(20);
    drop();
    rd_val = 8'h00;
    idle(4);
    chk("t2_rdata", bus.rdata, 8'h5C);
    chk("t2_addr",  bus.address, 16'h0003);
    chk("t2_wdata", bus.wdata, 8'hA5);
    chk("t2_count", bus.xfer_count, 16'd2);

    // 3: simultaneous rise -> write only + overrun, then clear
    raise(1'b1, 1'b1, 16'h0040, 8'h3C, e0);
    evq.push_back('{e0 + LAT, EV_WR, 16'h0040, 8'h3C});
    evq.push_back('{e0 + LAT - 1, EV_OVR, 16'h0, 8'h0});
    idle(20);
    drop();
    chk("t3_overrun", bus.overrun, 1'b1);
    chk("t3_count",   bus.xfer_count, 16'd3);
    clr_pulse();
    idle(1);
    chk("t3_clr_overrun", bus.overrun, 1'b0);
    chk("t3_clr_count",   bus.xfer_count, 16'd0);

    // 3b: read rising while a write waits for its enable to fall -> dropped, overrun
    raise(1'b1, 1'b0, 16'h0041, 8'h11, e0);
    evq.push_back('{e0 + LAT, EV_WR, 16'h0041, 8'h11});
    idle(10);
    @(negedge clk);
    bus.rd_en_sclk = 1'b1;
    e1 = edges;
    evq.push_back('{e1 + N + 2, EV_OVR, 16'h0, 8'h0});
    idle(12);
    drop();
    chk("t3b_overrun", bus.overrun, 1'b1);
    chk("t3b_count",   bus.xfer_count, 16'd1);

    // 3c: clear lands on the strobe cycle -> count ends at zero
    raise(1'b1, 1'b0, 16'h0050, 8'h22, e0);
    evq.push_back('{e0 + LAT, EV_WR, 16'h0050, 8'h22});
    repeat (LAT - 2) @(negedge clk);
    clr_pulse();
    idle(10);
    drop();
    chk("t3c_count",   bus.xfer_count, 16'd0);
    chk("t3c_overrun", bus.overrun, 1'b0);
    chk("t3c_addr",    bus.address, 16'h0050);

    // 4: enable already high at reset release -> no strobe until it re-arms
    @(negedge clk);
    bus.address_sclk = 16'h0099; bus.wdata_sclk = 8'h99; bus.wr_en_sclk = 1'b1;
    #2 rst_n = 1'b0;
    idle(3);
    #2 rst_n = 1'b1;
    idle(15);
    chk("t4_no_strobe_count", bus.xfer_count, 16'd0);
    drop();
    write(16'h0123, 8'h5A, 15);
    chk("t4_count", bus.xfer_count, 16'd1);
    chk("t4_addr",  bus.address, 16'h0123);

    // 5: reset in the strobe cycle truncates it; the held request never strobes
    raise(1'b1, 1'b0, 16'h0200, 8'hC3, e0);
    evq.push_back('{e0 + LAT, EV_WR, 16'h0200, 8'hC3});
    repeat (LAT) @(posedge clk);
    #2;
    chk("t5_strobe_up", bus.wr_strobe, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_strobe_cut", bus.wr_strobe, 1'b0);
    chk("t5_addr",       bus.address, 16'h0000);
    chk("t5_count",      bus.xfer_count, 16'h0000);
    idle(3);
    #2 rst_n = 1'b1;
    idle(15);
    drop();
    chk("t5_no_restrobe", bus.xfer_count, 16'h0000);

    // 6: counter wraps, overrun untouched
    raise(1'b1, 1'b1, 16'h0300, 8'h44, e0);
    evq.push_back('{e0 + LAT, EV_WR, 16'h0300, 8'h44});
    evq.push_back('{e0 + LAT - 1, EV_OVR, 16'h0, 8'h0});
    idle(15);
    drop();
    @(posedge clk);
    #1;
    force dut.xfer_q = 16'hFFFF;
    evq.push_back('{edges, EV_LOAD, 16'hFFFF, 8'h0});
    @(posedge clk);
    #1;
    release dut.xfer_q;
    idle(2);
    chk("t6_preload", bus.xfer_count, 16'hFFFF);
    write(16'h0301, 8'h45, 15);
    chk("t6_wrap",    bus.xfer_count, 16'h0000);
    chk("t6_overrun", bus.overrun, 1'b1);

    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
